// File: rtl/bg_pic_fetch.sv
// Background-picture fetch: SDRAM download writer plus display-time pixel prefetch FIFO.
// Define BG_PIC_FETCH_STATS_EN to make o_underrun_cnt live; otherwise it is tied to zero.
module bg_pic_fetch #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_W     = 24
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic              i_ce_pix,
   input  logic              i_hblank,
   input  logic              i_vblank,
   input  logic              i_vs,
   input  logic              i_dl_active,
   input  logic              i_dl_wr,
   input  logic [24:0]       i_dl_addr,
   input  logic [7:0]        i_dl_data,
   output logic [ADDR_W-1:0] o_sd_addr,
   output logic [15:0]       o_sd_din,
   output logic              o_sd_req,
   output logic              o_sd_rnw,
   input  logic [31:0]       i_sd_dout,
   input  logic              i_sd_ack,
   output logic [7:0]        o_bg_r,
   output logic [7:0]        o_bg_g,
   output logic [7:0]        o_bg_b,
   output logic [7:0]        o_bg_a,
   output logic [7:0]        o_underrun_cnt
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StFill, StRun, StDl} state_e;

   state_e            r_state, w_state_d;
   logic              r_vs;
   logic [31:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_outstanding, r_stale;
   logic              r_push_vld;
   logic [31:0]       r_push_data;
   logic [3:0]        r_drop;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [7:0]        r_lo_byte;
   logic [ADDR_W-1:0] r_sd_addr;
   logic [15:0]       r_sd_din;
   logic              r_sd_req, r_sd_rnw;
   logic [31:0]       r_pix;

   logic       w_vs_rise, w_fetch_st, w_flush, w_pop_cyc, w_empty, w_pop, w_underrun;
   logic       w_push, w_issue, w_ack_take, w_ack_keep, w_dl_write, w_dl_low;
   logic [3:0] w_drop_inc, w_drop_d;

   assign w_vs_rise  = i_vs & ~r_vs;
   assign w_fetch_st = (r_state == StFill) || (r_state == StRun);
   assign w_flush    = w_vs_rise | ~i_enable | ~w_fetch_st;
   assign w_empty    = (r_count == '0);
   assign w_pop_cyc  = i_ce_pix & ~i_hblank & ~i_vblank & i_enable & w_fetch_st;
   assign w_pop      = w_pop_cyc & ~w_empty;
   assign w_underrun = w_pop_cyc & w_empty;
   assign w_ack_take = i_sd_ack & r_outstanding;
   assign w_ack_keep = w_ack_take & ~r_stale & ~w_vs_rise;
   assign w_issue    = w_fetch_st & i_enable & ~i_dl_active & ~w_vs_rise & ~r_outstanding &
                       ~r_push_vld & (r_count < CNT_W'(FIFO_DEPTH));
   assign w_dl_write = (r_state == StDl) & i_dl_wr & i_dl_addr[0];
   assign w_dl_low   = (r_state == StDl) & i_dl_wr & ~i_dl_addr[0];

   // Drop decision is made as the word lands, counting an underrun in the same cycle, so a
   // word already in flight for an underrun pixel is discarded rather than shifting the line.
   assign w_drop_inc = (w_underrun && r_drop != 4'hF) ? r_drop + 4'd1 : r_drop;

   always_comb begin
      w_push   = 1'b0;
      w_drop_d = w_drop_inc;
      if (r_push_vld && !w_flush) begin
         if (w_drop_inc != 4'd0) w_drop_d = w_drop_inc - 4'd1;
         else                    w_push   = 1'b1;
      end
      if (w_vs_rise) w_drop_d = 4'd0;
   end

   always_comb begin
      w_state_d = r_state;
      if (i_dl_active) begin
         w_state_d = StDl;
      end else begin
         case (r_state)
            StDl:    w_state_d = StIdle;
            StIdle:  if (w_vs_rise && i_enable) w_state_d = StFill;
            StFill:  if (w_vs_rise) w_state_d = StFill;
                     else if (w_pop_cyc) w_state_d = StRun;
            StRun:   if (w_vs_rise) w_state_d = StFill;
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= StIdle;
      else         r_state <= w_state_d;
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_push_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_vs          <= 1'b0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= 1'b0;
         r_stale       <= 1'b0;
         r_push_vld    <= 1'b0;
         r_push_data   <= '0;
         r_drop        <= 4'd0;
         r_rd_addr     <= '0;
         r_lo_byte     <= 8'd0;
         r_sd_addr     <= '0;
         r_sd_din      <= 16'd0;
         r_sd_req      <= 1'b0;
         r_sd_rnw      <= 1'b0;
         r_pix         <= 32'd0;
      end else begin
         r_vs        <= i_vs;
         r_push_vld  <= w_ack_keep;
         r_push_data <= i_sd_dout;
         r_drop      <= w_drop_d;
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
         end
         if (w_issue)         r_outstanding <= 1'b1;
         else if (w_ack_take) r_outstanding <= 1'b0;
         // A read still in flight at frame start belongs to the old frame.
         if (w_ack_take)                      r_stale <= 1'b0;
         else if (w_vs_rise && r_outstanding) r_stale <= 1'b1;
         if (w_vs_rise)    r_rd_addr <= '0;
         else if (w_issue) r_rd_addr <= r_rd_addr + ADDR_W'(2);
         if (w_dl_low) r_lo_byte <= i_dl_data;
         r_sd_req <= w_issue | w_dl_write;
         if (w_issue) begin
            r_sd_addr <= r_rd_addr;
            r_sd_rnw  <= 1'b1;
         end else if (w_dl_write) begin
            r_sd_addr <= ADDR_W'(i_dl_addr[24:1]);
            r_sd_din  <= {i_dl_data, r_lo_byte};
            r_sd_rnw  <= 1'b0;
         end
         if (!i_enable)       r_pix <= 32'd0;
         else if (w_pop)      r_pix <= r_mem[r_rd_ptr];
         else if (w_underrun) r_pix <= 32'd0;
      end
   end

`ifdef BG_PIC_FETCH_STATS_EN
   logic [7:0] r_underrun;
   always_ff @(posedge i_clk) begin
      if (i_reset || w_vs_rise)                r_underrun <= 8'd0;
      else if (w_underrun && r_underrun != 8'hFF) r_underrun <= r_underrun + 8'd1;
   end
   assign o_underrun_cnt = r_underrun;
`else
   assign o_underrun_cnt = 8'd0;
`endif

`ifndef SYNTHESIS
   a_no_push_full: assert property (@(posedge i_clk) disable iff (i_reset)
      !(w_push && r_count == CNT_W'(FIFO_DEPTH)));
`endif

   assign o_sd_addr = r_sd_addr;
   assign o_sd_din  = r_sd_din;
   assign o_sd_req  = r_sd_req;
   assign o_sd_rnw  = r_sd_rnw;
   assign {o_bg_a, o_bg_b, o_bg_g, o_bg_r} = r_pix;

endmodule

// File: tb/tb_bg_pic_fetch.sv
// Scoreboard bench for bg_pic_fetch: download writes, prefetch, underrun realignment, frame restart.
module tb_bg_pic_fetch;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset, enable, ce_pix, hblank, vblank, vs, dl_active, dl_wr;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic [23:0] sd_addr;
   logic [15:0] sd_din;
   logic        sd_req, sd_rnw, sd_ack;
   logic [31:0] sd_dout;
   logic [7:0]  bg_r, bg_g, bg_b, bg_a, underrun_cnt;

   always #5 clk = ~clk;

   bg_pic_fetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(24)) dut (
      .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_ce_pix(ce_pix),
      .i_hblank(hblank), .i_vblank(vblank), .i_vs(vs), .i_dl_active(dl_active),
      .i_dl_wr(dl_wr), .i_dl_addr(dl_addr), .i_dl_data(dl_data),
      .o_sd_addr(sd_addr), .o_sd_din(sd_din), .o_sd_req(sd_req), .o_sd_rnw(sd_rnw),
      .i_sd_dout(sd_dout), .i_sd_ack(sd_ack),
      .o_bg_r(bg_r), .o_bg_g(bg_g), .o_bg_b(bg_b), .o_bg_a(bg_a),
      .o_underrun_cnt(underrun_cnt)
   );

   typedef struct packed {logic [31:0] pix; logic allow_zero;} pix_exp_t;
   typedef struct packed {logic [23:0] addr; logic [15:0] din;} wr_exp_t;
   pix_exp_t pix_q[$];
   wr_exp_t  wr_q[$];

   int n_tests = 0, n_fail = 0;
   int lat = 3, mdl_cnt = 0;
   logic [23:0] mdl_addr = '0;
   int exp_rd_addr = 0, reads_frame = 0, pops_frame = 0, zero_cnt = 0, pix_idx = 0;
   bit tb_pop = 0, in_dl = 0, no_req = 0, addr_restart = 0;

   function automatic logic [31:0] tag(input int unsigned a);
      logic [7:0] b;
      b = a[7:0];
      return {8'hA5, 8'h5A, ~b, b};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_pixel(input bit allow_zero);
      pix_exp_t e;
      e.pix = tag(2 * pix_idx);
      e.allow_zero = allow_zero;
      pix_q.push_back(e);
      pix_idx++;
      ce_pix = 1'b1;
      tb_pop = 1'b1;
      step();
      ce_pix = 1'b0;
      tb_pop = 1'b0;
      repeat (7) step();
   endtask

   task automatic dl_byte(input int unsigned a, input logic [7:0] d);
      dl_wr = 1'b1;
      dl_addr = 25'(a);
      dl_data = d;
      step();
      dl_wr = 1'b0;
      step();
   endtask

   // SDRAM read model: acks one read after 'lat' cycles with address-tagged data.
   initial begin
      sd_ack = 1'b0;
      sd_dout = '0;
      forever begin
         @(posedge clk);
         #1;
         sd_ack = 1'b0;
         if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
               sd_ack = 1'b1;
               sd_dout = tag(int'(mdl_addr));
            end
         end
         if (sd_req && sd_rnw) begin
            mdl_addr = sd_addr;
            mdl_cnt = lat;
         end
      end
   end

   // Monitor: checks requests and popped pixels against the scoreboard queues.
   initial begin
      bit pop_prev;
      pix_exp_t pe;
      wr_exp_t we;
      logic [31:0] got;
      pop_prev = 0;
      forever begin
         @(negedge clk);
         if (sd_req) begin
            if (sd_rnw) begin
               check("read_while_blocked", 64'(in_dl | no_req), 64'd0);
               check("rd_addr", 64'(sd_addr), 64'(exp_rd_addr));
               exp_rd_addr += 2;
               reads_frame++;
               check("fifo_bound", 64'((reads_frame - pops_frame) <= DEPTH), 64'd1);
            end else if (wr_q.size() == 0) begin
               check("unexpected_write", 64'(sd_addr), 64'hFFFF_FFFF);
            end else begin
               we = wr_q.pop_front();
               check("wr_addr", 64'(sd_addr), 64'(we.addr));
               check("wr_data", 64'(sd_din), 64'(we.din));
            end
         end
         if (addr_restart) begin
            exp_rd_addr = 0;
            reads_frame = 0;
            pops_frame = 0;
            addr_restart = 0;
         end
         if (pop_prev) begin
            pops_frame++;
            got = {bg_a, bg_b, bg_g, bg_r};
            if (pix_q.size() == 0) begin
               check("unexpected_pixel", 64'(got), 64'hFFFF_FFFF_FFFF);
            end else begin
               pe = pix_q.pop_front();
               if (pe.allow_zero && got == 32'd0) zero_cnt++;
               else check("pixel", 64'(got), 64'(pe.pix));
`ifdef BG_PIC_FETCH_STATS_EN
               check("underrun_cnt", 64'(underrun_cnt), 64'(zero_cnt));
`else
               check("underrun_cnt_off", 64'(underrun_cnt), 64'd0);
`endif
            end
         end
         pop_prev = tb_pop;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int waited;
      wr_exp_t w;
      reset = 1'b1; enable = 1'b0; ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b0; vs = 1'b0;
      dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
      repeat (3) step();
      check("reset_outputs", 64'({bg_a, bg_b, bg_g, bg_r, sd_req, sd_rnw, underrun_cnt}), 64'd0);
      check("reset_sd", 64'({sd_addr, sd_din}), 64'd0);
      reset = 1'b0;

      // Download four bytes; expect two 16-bit writes and no reads.
      in_dl = 1; dl_active = 1'b1;
      repeat (2) step();
      w.addr = 24'd0; w.din = 16'h2211; wr_q.push_back(w);
      w.addr = 24'd1; w.din = 16'h4433; wr_q.push_back(w);
      dl_byte(0, 8'h11); dl_byte(1, 8'h22); dl_byte(2, 8'h33); dl_byte(3, 8'h44);
      repeat (3) step();
      dl_active = 1'b0;
      repeat (3) step();
      in_dl = 0;
      check("dl_writes_done", 64'(wr_q.size()), 64'd0);

      // Frame 1, ack latency 3: FIFO fills to depth, pixels map to addr 2N.
      enable = 1'b1;
      step();
      vs = 1'b1; addr_restart = 1; zero_cnt = 0; pix_idx = 0;
      repeat (4) step();
      vs = 1'b0;
      repeat (150) step();
      check("fill_reads", 64'(reads_frame), 64'(DEPTH));
      hblank = 1'b0;
      repeat (24) pop_pixel(0);
      hblank = 1'b1;
      repeat (60) step();

      // Frame 2, ack latency 40: underruns output 0, later words dropped to realign.
      lat = 40;
      vs = 1'b1; addr_restart = 1; zero_cnt = 0; pix_idx = 0;
      repeat (4) step();
      vs = 1'b0;
      repeat (450) step();
      hblank = 1'b0;
      repeat (20) pop_pixel(1);
      hblank = 1'b1;
      repeat (1000) step();
      hblank = 1'b0;
      repeat (4) pop_pixel(0);
      check("saw_underrun", 64'(zero_cnt > 0), 64'd1);

      // Frame start while a read is outstanding: stale ack dropped, restart at addr 0.
      waited = 0;
      while (!(mdl_cnt > 10) && waited < 200) begin
         step();
         waited++;
      end
      check("outstanding_wait", 64'(waited < 200), 64'd1);
      vs = 1'b1; addr_restart = 1; zero_cnt = 0; pix_idx = 0;
      hblank = 1'b1;
      repeat (4) step();
      vs = 1'b0;
      check("underrun_clr", 64'(underrun_cnt), 64'd0);
      repeat (600) step();
      hblank = 1'b0;
      repeat (2) pop_pixel(0);

      // enable=0 mid-line: outputs clear next cycle, no reads.
      enable = 1'b0;
      step();
      check("disable_outputs", 64'({bg_a, bg_b, bg_g, bg_r}), 64'd0);
      no_req = 1;
      repeat (20) step();
      no_req = 0;

      // Reset during download: outputs clear next cycle, then idle with no reads.
      in_dl = 1; dl_active = 1'b1;
      repeat (2) step();
      w.addr = 24'd2; w.din = 16'h6655; wr_q.push_back(w);
      dl_wr = 1'b1; dl_addr = 25'd4; dl_data = 8'h55;
      step();
      dl_addr = 25'd5; dl_data = 8'h66;
      step();
      dl_wr = 1'b0;
      reset = 1'b1;
      step();
      check("reset_mid_dl_sd", 64'({sd_req, sd_addr, sd_din}), 64'd0);
      check("reset_mid_dl_pix", 64'({bg_a, bg_b, bg_g, bg_r, underrun_cnt}), 64'd0);
      reset = 1'b0; dl_active = 1'b0; in_dl = 0; enable = 1'b1; addr_restart = 1;
      step();
      no_req = 1;
      repeat (30) step();
      no_req = 0;
      repeat (5) step();
      check("pix_queue_empty", 64'(pix_q.size()), 64'd0);
      check("wr_queue_empty", 64'(wr_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
